id_hazard_ctrl: RTL and testbench

//  Register-scoreboard issue controller for the decode stage. Tracks in-flight regfile

---
 rtl/id_hazard_ctrl_pkg.sv | 16 +
 rtl/id_hazard_ctrl_pend_counter.sv | 26 ++
 rtl/id_hazard_ctrl.sv | 88 ++++++++
 tb/tb_id_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared LC-3b decode types and scoreboard sizing.
package lc3b_types;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned STAT_W   = 16;

  typedef logic [REG_W-1:0]  lc3b_reg;
  typedef logic [CNT_W-1:0]  lc3b_pend_cnt;
  typedef logic [STAT_W-1:0] lc3b_stat;

  localparam lc3b_reg      LC3B_R7  = 3'b111;
  localparam lc3b_pend_cnt PEND_MAX = '1;

endpackage

// File: rtl/id_hazard_ctrl_pend_counter.sv
// Per-register count of in-flight regfile writes; flags a retire with nothing pending.
module sb_pend_counter
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output lc3b_pend_cnt count,
  output logic         underflow
);

  always_comb underflow = dec & ~inc & (count == '0);

  // inc and dec together cancel; the issue side never increments a saturated counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc & ~dec) begin
      count <= count + CNT_W'(1);
    end else if (dec & ~inc & (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage scoreboard: stalls ID on pending source/saturated-dest writes, drives ID->EX issue.
module id_hazard_ctrl
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     id_valid,
  input  lc3b_reg  id_sr1,
  input  logic     id_sr1_used,
  input  lc3b_reg  id_sr2,
  input  logic     id_sr2_used,
  input  lc3b_reg  id_dest,
  input  logic     id_dest_r7,
  input  logic     id_writes,
  input  logic     ex_ready,
  input  logic     flush,
  input  logic     wb_valid,
  input  lc3b_reg  wb_dest,
  input  logic     stat_clr,
  output logic     issue,
  output logic     bubble,
  output logic     stall,
  output logic     busy,
  output logic     sb_err,
  output lc3b_stat stall_cycles
);

  lc3b_pend_cnt          pend [NUM_REGS];
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic [NUM_REGS-1:0]   uflow_vec;
  lc3b_reg               eff_dest;
  logic                  hazard;

  always_comb begin
    eff_dest = id_dest_r7 ? LC3B_R7 : id_dest;
    hazard   = id_valid & ((id_sr1_used & (pend[id_sr1] != '0))
                         | (id_sr2_used & (pend[id_sr2] != '0))
                         | (id_writes   & (pend[eff_dest] == PEND_MAX)));
    issue    = id_valid & ~hazard & ex_ready & ~flush;
    bubble   = ~issue;
    stall    = id_valid & ~flush & (hazard | ~ex_ready);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    always_comb begin
      inc_vec[r] = issue & id_writes & (eff_dest == REG_W'(r));
      dec_vec[r] = wb_valid & (wb_dest == REG_W'(r));
    end

    sb_pend_counter u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .count     (pend[r]),
      .underflow (uflow_vec[r])
    );
  end

  // busy depends only on counter state
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy = busy | (pend[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_err <= 1'b0;
    end else if (|uflow_vec) begin
      sb_err <= 1'b1;
    end
  end

  // clear beats increment; increment saturates at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scenario bench for the decode-stage scoreboard.
module tb_id_hazard_ctrl;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     id_valid, id_sr1_used, id_sr2_used, id_dest_r7, id_writes;
  lc3b_reg  id_sr1, id_sr2, id_dest, wb_dest;
  logic     ex_ready, flush, wb_valid, stat_clr;
  logic     issue, bubble, stall, busy, sb_err;
  lc3b_stat stall_cycles;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .id_dest(id_dest), .id_dest_r7(id_dest_r7), .id_writes(id_writes),
    .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .stat_clr(stat_clr), .issue(issue), .bubble(bubble), .stall(stall),
    .busy(busy), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_sr1 = 0; id_sr1_used = 0; id_sr2 = 0; id_sr2_used = 0;
    id_dest = 0; id_dest_r7 = 0; id_writes = 0; ex_ready = 1; flush = 0;
    wb_valid = 0; wb_dest = 0; stat_clr = 0;
  endtask

  task automatic drive_id(input lc3b_reg s1, input logic s1u, input lc3b_reg s2,
                          input logic s2u, input lc3b_reg d, input logic r7, input logic w);
    id_valid = 1; id_sr1 = s1; id_sr1_used = s1u; id_sr2 = s2; id_sr2_used = s2u;
    id_dest = d; id_dest_r7 = r7; id_writes = w;
  endtask

  task automatic retire(input lc3b_reg d);
    idle(); wb_valid = 1; wb_dest = d;
    tick();
    idle();
  endtask

  task automatic clear_stats();
    idle(); stat_clr = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    #2;
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    ntests++; if (sb_err !== 1'b0) begin nfail++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
    ntests++; if (stall_cycles !== 16'd0) begin nfail++; $display("FAIL reset_stat: got %0d want 0", stall_cycles); end
    ntests++; if (issue !== 1'b0 || stall !== 1'b0 || bubble !== 1'b1) begin
      nfail++; $display("FAIL reset_ctrl: got issue=%b stall=%b bubble=%b want 0 0 1", issue, stall, bubble); end
    tick(); reset_n = 1;
    tick();
  endtask

  task automatic test_raw();
    clear_stats();
    drive_id(0, 0, 0, 0, 3'd1, 0, 1);
    #1;
    ntests++; if (issue !== 1'b1) begin nfail++; $display("FAIL raw_first_issue: got %b want 1", issue); end
    tick();
    drive_id(3'd1, 1, 0, 0, 3'd2, 0, 1);
    #1;
    ntests++; if (stall !== 1'b1 || bubble !== 1'b1 || issue !== 1'b0 || busy !== 1'b1) begin
      nfail++; $display("FAIL raw_stall: got stall=%b bubble=%b issue=%b busy=%b want 1 1 0 1", stall, bubble, issue, busy); end
    tick();
    tick();
    wb_valid = 1; wb_dest = 3'd1;
    #1;
    ntests++; if (stall !== 1'b1 || issue !== 1'b0) begin
      nfail++; $display("FAIL raw_no_bypass: got stall=%b issue=%b want 1 0", stall, issue); end
    tick();
    wb_valid = 0;
    #1;
    ntests++; if (issue !== 1'b1 || stall !== 1'b0) begin
      nfail++; $display("FAIL raw_release: got issue=%b stall=%b want 1 0", issue, stall); end
    ntests++; if (stall_cycles !== 16'd3) begin nfail++; $display("FAIL raw_stat: got %0d want 3", stall_cycles); end
    tick();
    retire(3'd2);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL raw_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_inc_dec();
    idle();
    drive_id(0, 0, 0, 0, 3'd4, 0, 1);
    tick();
    drive_id(0, 0, 0, 0, 3'd4, 0, 1);
    wb_valid = 1; wb_dest = 3'd4;
    #1;
    ntests++; if (issue !== 1'b1) begin nfail++; $display("FAIL incdec_issue: got %b want 1", issue); end
    tick();
    idle();
    drive_id(3'd4, 1, 0, 0, 0, 0, 0);
    #1;
    ntests++; if (busy !== 1'b1 || stall !== 1'b1) begin
      nfail++; $display("FAIL incdec_held: got busy=%b stall=%b want 1 1", busy, stall); end
    retire(3'd4);
    ntests++; if (busy !== 1'b0 || sb_err !== 1'b0) begin
      nfail++; $display("FAIL incdec_count_one: got busy=%b sb_err=%b want 0 0", busy, sb_err); end
  endtask

  task automatic test_saturation();
    idle();
    for (int k = 0; k < 3; k++) begin
      drive_id(0, 0, 0, 0, 3'd5, 0, 1);
      #1;
      ntests++; if (issue !== 1'b1) begin nfail++; $display("FAIL sat_fill%0d: got issue=%b want 1", k, issue); end
      tick();
    end
    drive_id(0, 0, 0, 0, 3'd5, 0, 1);
    #1;
    ntests++; if (stall !== 1'b1 || issue !== 1'b0) begin
      nfail++; $display("FAIL sat_stall: got stall=%b issue=%b want 1 0", stall, issue); end
    tick();
    wb_valid = 1; wb_dest = 3'd5;
    #1;
    ntests++; if (stall !== 1'b1) begin nfail++; $display("FAIL sat_no_bypass: got stall=%b want 1", stall); end
    tick();
    wb_valid = 0;
    #1;
    ntests++; if (issue !== 1'b1) begin nfail++; $display("FAIL sat_release: got issue=%b want 1", issue); end
    tick();
    retire(3'd5);
    retire(3'd5);
    ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL sat_partial: got busy=%b want 1", busy); end
    retire(3'd5);
    ntests++; if (busy !== 1'b0 || sb_err !== 1'b0) begin
      nfail++; $display("FAIL sat_drain: got busy=%b sb_err=%b want 0 0", busy, sb_err); end
  endtask

  task automatic test_jsr();
    idle();
    drive_id(0, 0, 0, 0, 3'd2, 1, 1);
    tick();
    drive_id(3'd2, 1, 0, 0, 0, 0, 0);
    #1;
    ntests++; if (issue !== 1'b1) begin nfail++; $display("FAIL jsr_r2_free: got issue=%b want 1", issue); end
    tick();
    drive_id(0, 0, 3'd7, 1, 0, 0, 0);
    #1;
    ntests++; if (stall !== 1'b1) begin nfail++; $display("FAIL jsr_r7_stall: got stall=%b want 1", stall); end
    tick();
    wb_valid = 1; wb_dest = 3'd7;
    tick();
    wb_valid = 0;
    #1;
    ntests++; if (issue !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL jsr_release: got issue=%b busy=%b want 1 0", issue, busy); end
    tick();
    idle();
  endtask

  task automatic test_flush_underflow();
    idle();
    drive_id(0, 0, 0, 0, 3'd0, 0, 0);
    ex_ready = 0;
    #1;
    ntests++; if (stall !== 1'b1 || issue !== 1'b0) begin
      nfail++; $display("FAIL exready_stall: got stall=%b issue=%b want 1 0", stall, issue); end
    tick();
    ex_ready = 1;
    drive_id(0, 0, 0, 0, 3'd1, 0, 1);
    tick();
    drive_id(3'd1, 1, 0, 0, 3'd3, 0, 1);
    flush = 1;
    #1;
    ntests++; if (stall !== 1'b0 || issue !== 1'b0 || bubble !== 1'b1) begin
      nfail++; $display("FAIL flush_ctrl: got stall=%b issue=%b bubble=%b want 0 0 1", stall, issue, bubble); end
    tick();
    idle();
    #1;
    ntests++; if (stall !== 1'b0 || issue !== 1'b0) begin
      nfail++; $display("FAIL novalid_ctrl: got stall=%b issue=%b want 0 0", stall, issue); end
    retire(3'd1);
    ntests++; if (busy !== 1'b0 || sb_err !== 1'b0) begin
      nfail++; $display("FAIL flush_no_inc: got busy=%b sb_err=%b want 0 0", busy, sb_err); end
    retire(3'd6);
    ntests++; if (sb_err !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL underflow: got sb_err=%b busy=%b want 1 0", sb_err, busy); end
    tick();
    ntests++; if (sb_err !== 1'b1) begin nfail++; $display("FAIL sb_err_sticky: got %b want 1", sb_err); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    drive_id(0, 0, 0, 0, 3'd3, 0, 1);
    tick();
    tick();
    drive_id(3'd3, 1, 0, 0, 0, 0, 0);
    tick();
    ntests++; if (stall_cycles !== 16'd1 || busy !== 1'b1) begin
      nfail++; $display("FAIL midrst_pre: got stat=%0d busy=%b want 1 1", stall_cycles, busy); end
    #1;
    reset_n = 0;
    #1;
    ntests++; if (busy !== 1'b0 || stall_cycles !== 16'd0 || sb_err !== 1'b0) begin
      nfail++; $display("FAIL midrst_async: got busy=%b stat=%0d sb_err=%b want 0 0 0", busy, stall_cycles, sb_err); end
    #1;
    reset_n = 1;
    #1;
    ntests++; if (issue !== 1'b1 || stall !== 1'b0) begin
      nfail++; $display("FAIL midrst_r3_issue: got issue=%b stall=%b want 1 0", issue, stall); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_inc_dec();
    test_saturation();
    test_jsr();
    test_flush_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
